// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: scoreboard entry type, forward select encodings and the stage match rule
`include "param.v"
package hazard_ctrl_pkg;
   localparam logic [1:0] FWD_NO  = `NO_forward;
   localparam logic [1:0] FWD_EX  = `EX_forward;
   localparam logic [1:0] FWD_MEM = `MEM_forward;
   localparam logic [1:0] FWD_WB  = `WB_forward;
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       we;
      logic       load;
   } sb_entry_t;
   localparam int SB_W = $bits(sb_entry_t);
   function automatic logic stage_match(sb_entry_t e, logic [4:0] r, logic used);
      return e.valid && e.we && (e.rd == r) && (r != 5'd0) && used;
   endfunction
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// hazard_ctrl_fwd_sel: per-operand forward select and load-use detection
//   r, used       : source register and whether it is read
//   ex, mem, wb   : scoreboard entries (sb_entry_t bits)
//   sel           : 2-bit forward select
//   lu_hazard     : operand depends on a load still in EX or MEM
module hazard_ctrl_fwd_sel
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0]      r,
   input  logic            used,
   input  logic [SB_W-1:0] ex,
   input  logic [SB_W-1:0] mem,
   input  logic [SB_W-1:0] wb,
   output logic [1:0]      sel,
   output logic            lu_hazard
);
   sb_entry_t ex_e, mem_e, wb_e;
   logic      ex_hit, mem_hit, wb_hit;
   always_comb begin
      ex_e    = sb_entry_t'(ex);
      mem_e   = sb_entry_t'(mem);
      wb_e    = sb_entry_t'(wb);
      ex_hit  = stage_match(ex_e, r, used);
      mem_hit = stage_match(mem_e, r, used);
      wb_hit  = stage_match(wb_e, r, used);
      // only the youngest match counts, so a younger ALU write hides an older load
      lu_hazard = ex_hit ? ex_e.load : (mem_hit & mem_e.load);
      sel = ex_hit  ? (ex_e.load  ? FWD_NO : FWD_EX)  :
            mem_hit ? (mem_e.load ? FWD_NO : FWD_MEM) :
            wb_hit  ? FWD_WB : FWD_NO;
   end
endmodule

// File: rtl/param.v
`ifndef PARAM_V
`define PARAM_V
`define NO_forward  2'b00
`define EX_forward  2'b01
`define MEM_forward 2'b10
`define WB_forward  2'b11
`endif

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: shadow scoreboard, forwarding selects, load-use stall, branch flush, perf counters
//   clk, rst_n                : clock, synchronous active-low reset
//   id_*                      : ID-stage instruction fields
//   ex_branch_taken           : EX redirects the PC this cycle
//   forwardA/B                : operand forward selects
//   pc_hold, ifid_hold        : stall controls
//   ifid_flush, idex_bubble   : bubble controls
//   stall_cnt, flush_cnt      : wrapping performance counters
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       id_rd,
   input  logic             id_reg_we,
   input  logic             id_is_load,
   input  logic             ex_branch_taken,
   output logic [1:0]       forwardA,
   output logic [1:0]       forwardB,
   output logic             pc_hold,
   output logic             ifid_hold,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   sb_entry_t        ex_q, mem_q, wb_q, ex_d, mem_d, wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             lu_a, lu_b, stall;
   hazard_ctrl_fwd_sel u_fwd_a (
      .r(id_rs1), .used(id_rs1_used), .ex(ex_q), .mem(mem_q), .wb(wb_q),
      .sel(forwardA), .lu_hazard(lu_a)
   );
   hazard_ctrl_fwd_sel u_fwd_b (
      .r(id_rs2), .used(id_rs2_used), .ex(ex_q), .mem(mem_q), .wb(wb_q),
      .sel(forwardB), .lu_hazard(lu_b)
   );
   always_comb begin
      // a taken branch kills the ID instruction, so it never holds the front end
      stall       = id_valid & (lu_a | lu_b) & ~ex_branch_taken;
      pc_hold     = stall;
      ifid_hold   = stall;
      ifid_flush  = ex_branch_taken;
      idex_bubble = stall | ex_branch_taken;
      ex_d        = idex_bubble ? '0 : '{valid: id_valid, rd: id_rd, we: id_reg_we, load: id_is_load};
      mem_d       = ex_q;
      wb_d        = mem_q;
      stall_cnt_d = stall_cnt_q + CNT_W'(stall);
      flush_cnt_d = flush_cnt_q + CNT_W'(ex_branch_taken);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven check of hazard_ctrl with an expected-value queue
module tb_hazard_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_rs1_used, id_rs2_used, id_reg_we, id_is_load, ex_branch_taken;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [1:0]  forwardA, forwardB;
   logic        pc_hold, ifid_hold, ifid_flush, idex_bubble;
   logic [31:0] stall_cnt, flush_cnt;
   int          n_vec = 0;
   int          n_miss = 0;

   hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_reg_we(id_reg_we), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
      .forwardA(forwardA), .forwardB(forwardB), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       we, ld, br;
      logic [1:0] fa, fb;
      logic       st, fl;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] exp_q[$];

   function automatic vec_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                               logic [4:0] rd, logic we, logic ld, logic br,
                               logic [1:0] fa, logic [1:0] fb, logic st, logic fl);
      vec_t x;
      x.v = v; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2; x.rd = rd;
      x.we = we; x.ld = ld; x.br = br; x.fa = fa; x.fb = fb; x.st = st; x.fl = fl;
      return x;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic drive(vec_t x);
      id_valid = x.v; id_rs1 = x.rs1; id_rs1_used = x.u1; id_rs2 = x.rs2; id_rs2_used = x.u2;
      id_rd = x.rd; id_reg_we = x.we; id_is_load = x.ld; ex_branch_taken = x.br;
      exp_q.push_back({x.fa, x.fb, x.st, x.st, x.fl, x.st | x.fl});
   endtask

   task automatic check_out(string name);
      logic [7:0] e;
      e = exp_q.pop_front();
      chk(name, {56'd0, forwardA, forwardB, pc_hold, ifid_hold, ifid_flush, idex_bubble}, {56'd0, e});
   endtask

   initial begin
      vec_t idle;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      //              v rs1 u1 rs2 u2 rd we ld br  fa     fb    st fl
      tbl.push_back(mk(1,  1, 1,  2, 1,  5, 1, 0, 0, 2'b00, 2'b00, 0, 0)); // add x5
      tbl.push_back(mk(1,  5, 1,  5, 1,  6, 1, 0, 0, 2'b01, 2'b01, 0, 0)); // sub x6,x5,x5
      tbl.push_back(mk(1,  5, 1,  0, 1,  7, 1, 0, 0, 2'b10, 2'b00, 0, 0)); // x5 at distance 2
      tbl.push_back(mk(1,  1, 1,  5, 1,  9, 1, 0, 0, 2'b00, 2'b11, 0, 0)); // x5 at distance 3
      tbl.push_back(mk(1,  5, 1,  6, 1, 10, 1, 0, 0, 2'b00, 2'b11, 0, 0)); // x5 distance 4, x6 distance 3
      tbl.push_back(mk(1,  1, 1,  0, 0,  7, 1, 1, 0, 2'b00, 2'b00, 0, 0)); // lw x7
      tbl.push_back(mk(1,  7, 1,  0, 1,  8, 1, 0, 0, 2'b00, 2'b00, 1, 0)); // add x8,x7,x0 stall 1
      tbl.push_back(mk(1,  7, 1,  0, 1,  8, 1, 0, 0, 2'b00, 2'b00, 1, 0)); // stall 2
      tbl.push_back(mk(1,  7, 1,  0, 1,  8, 1, 0, 0, 2'b11, 2'b00, 0, 0)); // from WB
      tbl.push_back(mk(1,  1, 1,  0, 0,  0, 1, 0, 0, 2'b00, 2'b00, 0, 0)); // addi x0
      tbl.push_back(mk(1,  0, 1,  0, 1, 11, 1, 0, 0, 2'b00, 2'b00, 0, 0)); // x0 never forwards
      tbl.push_back(mk(1,  1, 1,  0, 0, 12, 1, 0, 0, 2'b00, 2'b00, 0, 0)); // addi x12
      tbl.push_back(mk(1, 12, 1, 12, 0, 13, 1, 0, 0, 2'b01, 2'b00, 0, 0)); // rs2 unused
      tbl.push_back(mk(1,  1, 1,  0, 0,  3, 1, 1, 0, 2'b00, 2'b00, 0, 0)); // lw x3
      tbl.push_back(mk(1,  1, 1,  0, 0,  3, 1, 0, 0, 2'b00, 2'b00, 0, 0)); // addi x3
      tbl.push_back(mk(1,  3, 1,  3, 1,  4, 1, 0, 0, 2'b01, 2'b01, 0, 0)); // younger ALU hides load
      tbl.push_back(mk(1,  1, 1,  0, 0, 14, 1, 1, 0, 2'b00, 2'b00, 0, 0)); // lw x14
      tbl.push_back(mk(1, 14, 1, 14, 1, 15, 1, 0, 1, 2'b00, 2'b00, 0, 1)); // hazard + taken branch
      tbl.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0)); // idle
      rst_n = 1'b0;
      drive(idle);
      void'(exp_q.pop_front());
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_fwd", {60'd0, forwardA, forwardB}, 64'd0);
      chk("reset_ctl", {60'd0, pc_hold, ifid_hold, ifid_flush, idex_bubble}, 64'd0);
      chk("reset_cnt", {stall_cnt, flush_cnt}, 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         if (i != 0) begin
            @(posedge clk);
            #1;
         end
         drive(tbl[i]);
         @(negedge clk);
         check_out($sformatf("row%0d", i));
         if (i == 9) chk("stall_cnt_after_lu", 64'(stall_cnt), 64'd2);
      end
      @(posedge clk);
      #1 drive(idle);
      @(negedge clk);
      check_out("post_flush");
      chk("stall_cnt_flush", 64'(stall_cnt), 64'd2);
      chk("flush_cnt_flush", 64'(flush_cnt), 64'd1);
      // load then dependent consumer, reset during the first stall cycle
      @(posedge clk);
      #1 drive(mk(1, 1, 1, 0, 0, 20, 1, 1, 0, 2'b00, 2'b00, 0, 0));
      @(negedge clk);
      check_out("lw_x20");
      @(posedge clk);
      #1 drive(mk(1, 20, 1, 0, 0, 21, 1, 0, 0, 2'b00, 2'b00, 1, 0));
      @(negedge clk);
      check_out("stall_before_reset");
      rst_n = 1'b0;
      @(posedge clk);
      #1 drive(mk(1, 20, 1, 0, 0, 21, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      @(negedge clk);
      check_out("after_mid_stall_reset");
      chk("cnt_after_mid_stall_reset", {stall_cnt, flush_cnt}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1 drive(idle);
      @(negedge clk);
      check_out("idle_after_reset");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the five-stage pipeline. It keeps a shadow scoreboard of the destination registers in the EX, MEM and WB stages. From it, it drives the 2-bit forward selects of the two ID-stage operand forwarding muxes, the load-use stall and the branch flush. It also keeps stall and flush performance counters. It sits beside the ID stage and is the only source of `forwardA`, `forwardB`, `pc_hold`, `ifid_hold`, `ifid_flush` and `idex_bubble`.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  pipeline clock; the only clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  5 each  source register numbers.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the operand is actually read.
- `id_rd`  in  5  destination register.
- `id_reg_we`  in  1  the instruction writes `id_rd`.
- `id_is_load`  in  1  the instruction is a load; its data is valid only at WB.
- `ex_branch_taken`  in  1  the branch or jump in EX redirects the PC this cycle.
- `forwardA`, `forwardB`  out  2 each  operand select; encoding is given under Operation.
- `pc_hold`  out  1  PC keeps its value.
- `ifid_hold`  out  1  the IF/ID register keeps its value.
- `ifid_flush`  out  1  IF/ID loads a bubble.
- `idex_bubble`  out  1  ID/EX loads a bubble in place of the ID instruction.
- `stall_cnt`  out  `CNT_W`  number of load-use stall cycles.
- `flush_cnt`  out  `CNT_W`  number of taken-branch flushes.

## Operation
Forward select encoding, defined in `param.v`:
- `NO_forward` = 2'b00, use the register-file read data.
- `EX_forward` = 2'b01, use the EX ALU result.
- `MEM_forward` = 2'b10, use the MEM-stage ALU result.
- `WB_forward` = 2'b11, use the write-back data.

Shadow scoreboard:
- Three stage entries: `ex`, `mem`, `wb`. Each holds `{valid, rd, we, load}`.
- Every clock: `wb` takes `mem`, and `mem` takes `ex`.
- `ex` takes the ID instruction `{id_valid, id_rd, id_reg_we, id_is_load}`. If `idex_bubble` is asserted, `ex` takes the all-zero entry instead.

A stage S matches operand r when all of these hold: `S.valid`, `S.we`, `S.rd == r`, `r != 0`, and the operand's `used` bit is set.

Forward select, per operand, evaluated combinationally:
- First match in priority order EX, then MEM, then WB.
- EX match with `load=0` selects `EX_forward`.
- MEM match with `load=0` selects `MEM_forward`.
- WB match selects `WB_forward`, whether or not it is a load.
- No match selects `NO_forward`. Register x0 always gives `NO_forward`.
- EX or MEM match with `load=1` raises `lu_hazard`. The select is then don't-care; drive `NO_forward`.
- Only the highest-priority match counts. A younger non-load write to the same register hides an older load.

Control outputs:
- `lu_hazard` is computed only when `id_valid` is set.
- `stall = lu_hazard & ~ex_branch_taken`.
- `pc_hold = ifid_hold = stall`.
- `ifid_flush = ex_branch_taken`.
- `idex_bubble = stall | ex_branch_taken`.

Simultaneous events:
- Flush wins over stall. The ID instruction is on the wrong path and is killed, so nothing is held.
- A stall with the hazard still present next cycle stalls again. A load at distance 1 therefore produces exactly 2 stall cycles.

Counters:
- `stall_cnt` increments on each cycle with `stall=1`.
- `flush_cnt` increments on each cycle with `ex_branch_taken=1`.
- Both wrap modulo 2^`CNT_W`.

## Timing
- All forward selects and control outputs are combinational from the current ID inputs and the registered scoreboard. Zero-cycle latency.
- Scoreboard and counters update on the rising edge of `clk`.
- Reset is synchronous while `rst_n=0`:
  - all scoreboard entries become 0 and both counters become 0;
  - with `id_valid=0` and `ex_branch_taken=0`, this gives `forwardA = forwardB = 2'b00` and `pc_hold = ifid_hold = ifid_flush = idex_bubble = 0`.
- Reset asserted mid-stall drops the stall on the next edge, because the scoreboard is cleared.
- Dependence distances, counted in instructions after the producer:
  - ALU producer: distance 1 → EX, distance 2 → MEM, distance 3 → WB, no stalls.
  - Load producer: distance 1 → 2 stalls then WB; distance 2 → 1 stall then WB; distance 3 → WB, no stall.
  - Distance 4 or more → `NO_forward`. The register file writes first and reads second.

## Structure
- Put the `NO_forward`, `EX_forward`, `MEM_forward` and `WB_forward` macros in `param.v`, shared with the forwarding muxes. Add no new encodings.
- One natural sub-module is `fwd_sel`. It is instantiated twice, once per operand. Inputs: `r`, `used`, and the three scoreboard entries. Outputs: the 2-bit select and `lu_hazard`.
- The scoreboard registers, control logic and counters live in `hazard_ctrl`.

## Test plan
- Reset and ALU chain: hold reset, then issue `add x5` followed by `sub x6,x5,x5`. Expect `forwardA=forwardB=01` and no stall. At distance 2, expect `10`. At distance 3, expect `11`.
- Load-use: issue `lw x7` then `add x8,x7,x0`. Expect 2 cycles of `pc_hold=1` and `idex_bubble=1`, then `forwardA=11` and `forwardB=00`. `stall_cnt` reaches 2.
- x0 and unused operands: a producer writes x0, and a consumer with `rs1=0` follows. Expect `00`. A consumer with `rs2_used=0` that matches EX gets `forwardB=00`.
- Priority: issue `lw x3`, `addi x3`, `add x4,x3,x3`. Expect `EX_forward` on both operands and no stall, because the younger ALU write hides the load.
- Flush beats stall: a load-use hazard with `ex_branch_taken=1` in the same cycle. Expect `pc_hold=0`, `ifid_flush=1`, `idex_bubble=1`, `flush_cnt+1` and `stall_cnt` unchanged.
- Mid-stall reset: set `rst_n=0` during the first stall cycle. The next cycle shows all outputs at reset values and both counters 0.
